// File: rtl/neg_serial_pkg.sv
// neg_serial_pkg: shared FSM state encodings for the serial negator
package neg_serial_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/neg_bit_cell.sv
// neg_bit_cell: one-bit LSB-first one's/two's complement step
module neg_bit_cell (
  input  logic b,
  input  logic mode,
  input  logic seen_one,
  output logic res_bit,
  output logic seen_one_next
);
  // two's complement copies bits up to and including the first one, then inverts
  always_comb begin
    res_bit       = (mode && !seen_one) ? b : ~b;
    seen_one_next = seen_one | b;
  end
endmodule

// File: rtl/neg_serial.sv
// neg_serial: bit-serial one's/two's complement negator, N cycles per operand
module neg_serial
  import neg_serial_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [N-1:0] a,
  output logic [N-1:0] out,
  output logic         busy,
  output logic         done,
  output logic         ovf
);
  localparam int CW = $clog2(N);
  state_t         state_q, state_d;
  logic [N-1:0]   sh_q, sh_d, res_q, res_d, out_q, out_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           seen_q, seen_d, mode_q, mode_d, ovf_q, ovf_d;
  logic           res_bit, seen_next;
  neg_bit_cell u_cell (
    .b            (sh_q[0]),
    .mode         (mode_q),
    .seen_one     (seen_q),
    .res_bit      (res_bit),
    .seen_one_next(seen_next)
  );
  // next-state: latch on start, shift one bit per RUN cycle, publish on the last bit
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    res_d   = res_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start) begin
        sh_d    = a;
        mode_d  = mode;
        cnt_d   = '0;
        seen_d  = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        sh_d   = sh_q >> 1;
        res_d  = {res_bit, res_q[N-1:1]};
        seen_d = seen_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          out_d   = res_d;
          ovf_d   = mode_q & sh_q[0] & res_bit;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      res_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      mode_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      res_q   <= res_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      mode_q  <= mode_d;
      ovf_q   <= ovf_d;
    end
  end
  assign out  = out_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_neg_serial.sv
// tb_neg_serial: randomized and directed checks of neg_serial against an arithmetic model
module tb_neg_serial;
  localparam int N = 8;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] out;
  logic         busy, done, ovf;
  int n_cmp = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int           m_left = 0;
  bit           m_done = 1'b0;
  logic [N-1:0] m_out = '0;
  bit           m_ovf = 1'b0;
  logic [N-1:0] p_out = '0;
  bit           p_ovf = 1'b0;
  neg_serial #(.N(N)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .mode (mode),
    .a    (a),
    .out  (out),
    .busy (busy),
    .done (done),
    .ovf  (ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Model: an accepted start yields N busy cycles, then one done cycle, then idle
  always @(posedge clk) begin
    if (!rst_n) begin
      m_left = 0;
      m_done = 1'b0;
      m_out  = '0;
      m_ovf  = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_out  = p_out;
        m_ovf  = p_ovf;
        m_done = 1'b1;
      end
    end else if (start) begin
      m_left = N;
      p_out  = mode ? N'(-int'(a)) : ~a;
      p_ovf  = mode && (a == {1'b1, {(N-1){1'b0}}});
    end
  end
  // Every cycle: DUT outputs against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_left > 0));
      check("done", 32'(done), 32'(m_done));
      check("out", 32'(out), 32'(m_out));
      check("ovf", 32'(ovf), 32'(m_ovf));
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic go(input logic [N-1:0] av, input logic mv);
    start = 1'b1;
    a     = av;
    mode  = mv;
    step();
    start = 1'b0;
    a     = N'($urandom);
    mode  = 1'($urandom);
  endtask
  task automatic wait_done(output int bcy);
    bit seen = 1'b0;
    bcy = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) bcy++;
        step();
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask
  task automatic count_dones(input int cyc, output int nd);
    nd = 0;
    for (int k = 0; k < cyc; k++) begin
      step();
      if (done) nd++;
    end
  endtask
  initial begin
    int bcy, nd;
    step();
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;
    check("rst_out", 32'(out), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    step();
    go(8'h05, 1'b1);
    wait_done(bcy);
    check("m1_05_out", 32'(out), 32'hFB);
    check("m1_05_ovf", 32'(ovf), 32'h0);
    check("m1_05_busy_cycles", 32'(bcy), 32'd8);
    step();
    go(8'h05, 1'b0);
    wait_done(bcy);
    check("m0_05_out", 32'(out), 32'hFA);
    check("m0_05_ovf", 32'(ovf), 32'h0);
    check("m0_05_busy_cycles", 32'(bcy), 32'd8);
    step();
    go(8'h80, 1'b1);
    wait_done(bcy);
    check("m1_80_out", 32'(out), 32'h80);
    check("m1_80_ovf", 32'(ovf), 32'h1);
    check("model_80_ovf", 32'(m_ovf), 32'h1);
    step();
    check("hold_ovf", 32'(ovf), 32'h1);
    go(8'h00, 1'b1);
    wait_done(bcy);
    check("m1_00_out", 32'(out), 32'h00);
    check("m1_00_ovf", 32'(ovf), 32'h0);
    step();
    go(8'h05, 1'b1);
    step();
    step();
    start = 1'b1;
    a     = 8'hFF;
    step();
    start = 1'b0;
    wait_done(bcy);
    check("ign_start_out", 32'(out), 32'hFB);
    count_dones(12, nd);
    check("ign_start_extra_done", 32'(nd), 32'd0);
    check("ign_start_idle", 32'(busy), 32'h0);
    go(8'h05, 1'b1);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_out", 32'(out), 32'h0);
    check("abort_ovf", 32'(ovf), 32'h0);
    count_dones(12, nd);
    check("abort_no_done", 32'(nd), 32'd0);
    go(8'h01, 1'b1);
    wait_done(bcy);
    check("b2b_first_out", 32'(out), 32'hFF);
    check("model_first_out", 32'(m_out), 32'hFF);
    start = 1'b1;
    a     = 8'h7F;
    mode  = 1'b1;
    step();
    check("b2b_done_ignores_start", 32'(busy), 32'h0);
    step();
    check("b2b_second_accepted", 32'(busy), 32'h1);
    start = 1'b0;
    wait_done(bcy);
    check("b2b_second_out", 32'(out), 32'h81);
    check("b2b_second_busy_cycles", 32'(bcy), 32'd8);
    for (int k = 0; k < 3000; k++) begin
      step();
      start = ($urandom_range(0, 3) == 0);
      a     = N'($urandom);
      mode  = 1'($urandom);
      rst_n = ($urandom_range(0, 149) != 0);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (20) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
